alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//   Shares one ALU datapath (ADD/SUB/AND/OR, 2-bit opcode) between NUM_REQ
//   requesters using round-robin arbitration with valid/ready handshakes.
//   Accepts at most one operation per cycle and instantiates alu internally.
//   Returns each result through a single registered response slot, tagged
//   with the requester index. Sits between issuing clients and the ALU.
// PARAMETERS
//   ALU_WIDTH  16  operand/result width in bits (>=1)
//   NUM_REQ    4   number of requesters (>=1); ID_W = max(1,$clog2(NUM_REQ))
// PORTS
//   clk         in   1                  clock, all state on rising edge
//   rst         in   1                  async reset, active-high
//   req_valid   in   NUM_REQ            per-requester operation valid
//   req_ready   out  NUM_REQ            per-requester accept (one-hot or zero)
//   req_a       in   NUM_REQ*ALU_WIDTH  operand A, requester i at [i*W +: W]
//   req_b       in   NUM_REQ*ALU_WIDTH  operand B, same packing
//   req_opcode  in   NUM_REQ*2          00 add, 01 sub, 10 and, 11 or
//   rsp_valid   out  1                  response slot holds a result
//   rsp_ready   in   1                  consumer accepts response
//   rsp_result  out  ALU_WIDTH          ALU result
//   rsp_id      out  ID_W               index of requester that issued it
// BEHAVIOUR
//   - Reset (async, rst=1): rsp_valid=0, rsp_result=0, rsp_id=0, RR pointer
//     last_grant=NUM_REQ-1 (requester 0 has top priority first). req_ready is
//     combinational and forced to 0 while rst=1.
//   - Slot FSM: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
//     can_accept = EMPTY | (FULL & rsp_ready).
//   - Arbitration: combinational. Scan from (last_grant+1) mod NUM_REQ
//     upward, wrapping; the first i with req_valid[i]=1 wins.
//     req_ready[i]=1 only for the winner and only when can_accept.
//     req_ready may depend on req_valid; requesters must not make req_valid
//     depend on req_ready.
//   - Accept: req_valid[i] & req_ready[i]. Next edge: rsp_result <= ALU(i's
//     a,b,opcode), rsp_id <= i, rsp_valid <= 1, last_grant <= i.
//     Latency: 1 cycle from accept to rsp_valid.
//   - Pointer advances only on accept; it holds when nothing is granted.
//   - Response: FULL & rsp_ready & no accept -> EMPTY. FULL & rsp_ready &
//     accept -> stays FULL with new data (full throughput, 1 op/cycle).
//     FULL & !rsp_ready -> rsp_result/rsp_id held stable, req_ready all 0.
//   - Arithmetic: results are modulo 2^ALU_WIDTH with no carry or borrow
//     output (e.g. 0x0000-0x0001=0xFFFF, 0xFFFF+0x0001=0x0000).
//   - Requester rule: a, b and opcode must stay stable while valid & !ready.
//     Dropping valid before it is accepted is allowed; nothing is recorded.
//   - NUM_REQ=1: requester 0 is always the winner and rsp_id is always 0.
//   - Reset mid-operation: any result in the slot is discarded and the
//     pointer returns to its reset value; no response is produced afterwards.
// TESTING
//   1. Single op: req0 a=0x0005 b=0x0003 op=00 -> req_ready[0]=1 same cycle;
//      next cycle rsp_valid=1, rsp_result=0x0008, rsp_id=0.
//   2. Wrap math: a=0x0000 b=0x0001 op=01 -> 0xFFFF; a=0xF0F0 b=0x0FF0
//      op=10 -> 0x00F0; op=11 on the same operands -> 0xFFF0.
//   3. Fairness: all 4 valid every cycle, rsp_ready=1 -> grants 0,1,2,3,0,..;
//      rsp_id follows the same sequence one cycle later; 1 result per cycle.
//   4. Backpressure: rsp_ready=0 for 5 cycles while req1,req2 are valid ->
//      req_ready=0 and the response is held stable; on release, req2 or
//      req1 is granted per the pointer, and no op is lost or duplicated.
//   5. Sparse/skip: after a grant to 3, only req1 valid -> req1 is granted;
//      then req0 and req2 valid -> req2 is granted before req0.
//   6. Reset: assert rst while rsp_valid=1 with requests pending -> outputs
//      go to 0 immediately; after release, req0 has priority over req1..3.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one ADD/SUB/AND/OR datapath between NUM_REQ requesters.
// A requester is chosen by round-robin arbitration, one operation per cycle at most.
// Each result goes into a single registered response slot, tagged with the index
// of the requester that issued it.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    per-requester operation valid
//   req_ready    per-requester accept (one-hot or zero, combinational)
//   req_a/req_b  packed operands, requester i at [i*ALU_WIDTH +: ALU_WIDTH]
//   req_opcode   packed 2-bit opcodes (00 add, 01 sub, 10 and, 11 or)
//   rsp_valid    response slot holds a result
//   rsp_ready    consumer accepts the response
//   rsp_result   ALU result
//   rsp_id       index of the requester that issued the result
//
// Slot FSM
//   state | meaning
//   EMPTY | no result held; rsp_valid=0
//   FULL  | result held; rsp_valid=1, refilled in place when drained and accepting

module alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      2'b00: y = a + b;
      2'b01: y = a - b;
      2'b10: y = a & b;
      2'b11: y = a | b;
      default: y = '0;
    endcase
  end
endmodule

module alu_rr_arbiter #(
  parameter int ALU_WIDTH = 16,
  parameter int NUM_REQ   = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ALU_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ALU_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]         req_opcode,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ALU_WIDTH-1:0]         rsp_result,
  output logic [ID_W-1:0]              rsp_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  slot_state_t          state_q, state_d;
  logic [ID_W-1:0]      last_grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_found;
  logic                 can_accept;
  logic                 accept;
  logic [ALU_WIDTH-1:0] sel_a, sel_b, alu_y;
  logic [1:0]           sel_op;
  logic [ALU_WIDTH-1:0] result_q;
  logic [ID_W-1:0]      id_q;

  // Scan starts one past the last winner and wraps; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_op      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_W-1:0];
        sel_a       = req_a[idx*ALU_WIDTH +: ALU_WIDTH];
        sel_b       = req_b[idx*ALU_WIDTH +: ALU_WIDTH];
        sel_op      = req_opcode[idx*2 +: 2];
      end
    end
  end

  // A full slot can take new data in the same cycle it is drained.
  assign can_accept = (state_q == EMPTY) || rsp_ready;

  always_comb begin
    req_ready = '0;
    if (!rst && can_accept && grant_found)
      req_ready[grant_idx] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  alu #(.WIDTH(ALU_WIDTH)) u_alu (
    .a  (sel_a),
    .b  (sel_b),
    .op (sel_op),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      result_q   <= '0;
      id_q       <= '0;
      last_grant <= LAST_RST;
    end else begin
      state_q <= state_d;
      if (accept) begin
        result_q   <= alu_y;
        id_q       <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_result = result_q;
  assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_opcode;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic [1:0]     rsp_id;

  int tests;
  int fails;

  alu_rr_arbiter #(.ALU_WIDTH(W), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_opcode[i*2 +: 2] = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #12;
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    tests++;
    if (rsp_result !== 16'h0000) begin fails++; $display("FAIL reset_result got %h want 0000", rsp_result); end
    tests++;
    if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    req_valid = '0;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 16'h0005, 16'h0003, 2'b00);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 16'h0008 || rsp_id !== 2'd0) begin
      fails++; $display("FAIL single_rsp got v=%b r=%h id=%0d want v=1 r=0008 id=0", rsp_valid, rsp_result, rsp_id);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b want 0", rsp_valid); end
  endtask

  // pointer is at 0 on entry
  task automatic test_wrap_math();
    set_req(1, 16'h0000, 16'h0001, 2'b01);
    set_req(2, 16'hF0F0, 16'h0FF0, 2'b10);
    set_req(3, 16'hF0F0, 16'h0FF0, 2'b11);
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL wrap_sub_ready got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0100;
    tests++;
    if (rsp_result !== 16'hFFFF || rsp_id !== 2'd1) begin
      fails++; $display("FAIL wrap_sub got r=%h id=%0d want r=FFFF id=1", rsp_result, rsp_id);
    end
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL wrap_and_ready got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b1000;
    tests++;
    if (rsp_result !== 16'h00F0 || rsp_id !== 2'd2) begin
      fails++; $display("FAIL wrap_and got r=%h id=%0d want r=00F0 id=2", rsp_result, rsp_id);
    end
    tick();
    req_valid = '0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 16'hFFF0 || rsp_id !== 2'd3) begin
      fails++; $display("FAIL wrap_or got v=%b r=%h id=%0d want v=1 r=FFF0 id=3", rsp_valid, rsp_result, rsp_id);
    end
    tick();
    set_req(0, 16'hFFFF, 16'h0001, 2'b00);
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    tests++;
    if (rsp_result !== 16'h0000 || rsp_id !== 2'd0) begin
      fails++; $display("FAIL wrap_add got r=%h id=%0d want r=0000 id=0", rsp_result, rsp_id);
    end
    tick();
  endtask

  // pointer is at 0 on entry, so the sequence starts at 1
  task automatic test_fairness();
    int exp_seq[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) set_req(i, W'(i), 16'h0100, 2'b00);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      exp_rdy[exp_seq[c]] = 1'b1;
      #1;
      tests++;
      if (req_ready !== exp_rdy) begin
        fails++; $display("FAIL fair_ready[%0d] got %b want %b", c, req_ready, exp_rdy);
      end
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_seq[c]) || rsp_result !== 16'h0100 + W'(exp_seq[c])) begin
        fails++; $display("FAIL fair_rsp[%0d] got v=%b id=%0d r=%h want v=1 id=%0d r=%h", c,
                          rsp_valid, rsp_id, rsp_result, exp_seq[c], 16'h0100 + W'(exp_seq[c]));
      end
    end
    req_valid = '0;
    tick();
  endtask

  // pointer is at 0 on entry; get a grant to 3 first
  task automatic test_sparse();
    for (int i = 0; i < N; i++) set_req(i, W'(16'h0040 + i), 16'h0000, 2'b11);
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0010;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL sparse_req1 got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0101;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL sparse_req2 got %b want 0100", req_ready); end
    tick();
    tests++;
    if (rsp_id !== 2'd2 || rsp_result !== 16'h0042) begin
      fails++; $display("FAIL sparse_rsp2 got id=%0d r=%h want id=2 r=0042", rsp_id, rsp_result);
    end
    req_valid = 4'b0001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL sparse_req0 got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
  endtask

  // pointer is at 0 on entry
  task automatic test_backpressure();
    set_req(1, 16'h0010, 16'h0001, 2'b00);
    set_req(2, 16'h0020, 16'h0002, 2'b00);
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    tick();
    set_req(1, 16'h0030, 16'h0003, 2'b00);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_result !== 16'h0011 || rsp_id !== 2'd1) begin
        fails++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b r=%h id=%0d want rdy=0000 v=1 r=0011 id=1",
                          c, req_ready, rsp_valid, rsp_result, rsp_id);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_release got %b want 0100", req_ready); end
    tick();
    tests++;
    if (rsp_result !== 16'h0022 || rsp_id !== 2'd2) begin
      fails++; $display("FAIL bp_rsp2 got r=%h id=%0d want r=0022 id=2", rsp_result, rsp_id);
    end
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tests++;
    if (rsp_result !== 16'h0033 || rsp_id !== 2'd1) begin
      fails++; $display("FAIL bp_rsp1 got r=%h id=%0d want r=0033 id=1", rsp_result, rsp_id);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", rsp_valid); end
  endtask

  // pointer is at 1 on entry
  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) set_req(i, W'(16'h0A00 + i), 16'h0000, 2'b00);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      fails++; $display("FAIL rstmid_pre got v=%b id=%0d want v=1 id=2", rsp_valid, rsp_id);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_result !== 16'h0000 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL rstmid_async got v=%b r=%h id=%0d rdy=%b want v=0 r=0000 id=0 rdy=0000",
                        rsp_valid, rsp_result, rsp_id, req_ready);
    end
    tick();
    #1 rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_prio got rdy=%b v=%b want rdy=0001 v=0", req_ready, rsp_valid);
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tests++;
    if (rsp_id !== 2'd0 || rsp_result !== 16'h0A00) begin
      fails++; $display("FAIL rstmid_rsp got id=%0d r=%h want id=0 r=0A00", rsp_id, rsp_result);
    end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_opcode = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap_math();
    test_fairness();
    test_sparse();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
